mundo4_key_tx: RTL and testbench

Sequential transmitter for the 19-bit world-4 unlock word (Op, A..P, r, s). On request it selects one of two stored keys and shifts it out MSB-first over a per-bit valid/ready serial link. At the end of the frame it presents the completed word on a parallel bus shaped for the world-4 detector inputs. It sits between the game-control logic and the world-4 detector/serial link, and drives the other end of the detector's key interface.

---
 rtl/mundo4_key_tx.sv | 91 +++++++++
 tb/tb_mundo4_key_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mundo4_key_tx.sv
// mundo4_key_tx: MSB-first valid/ready serial transmitter for the 19-bit world-4 unlock word, with parallel key_bus.
// Define MUNDO4_TX_CHK_EN to add the registered KEY0/KEY1 match check; otherwise match is tied low.
module mundo4_key_tx #(
    parameter int GAP = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_key_sel,
    input  logic        i_ser_ready,
    output logic        o_ser_data,
    output logic        o_ser_valid,
    output logic        o_ser_sof,
    output logic        o_busy,
    output logic        o_done,
    output logic [18:0] o_key_bus,
    output logic        o_match
);
    localparam logic [18:0] KEY0 = 19'h29810;
    localparam logic [18:0] KEY1 = 19'h3FFFF;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN, S_GAP} state_t;

    state_t          r_state, w_next;
    logic [18:0]     r_shreg, r_key, r_key_bus;
    logic [4:0]      r_cnt;
    logic [GW-1:0]   r_gcnt;
    logic            w_xfer, w_last;
    logic [18:0]     w_sel;

    assign w_sel  = i_key_sel ? KEY1 : KEY0;
    assign w_xfer = (r_state == S_SHIFT) && i_ser_ready;
    assign w_last = w_xfer && (r_cnt == 5'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_FIN;
            S_FIN:   w_next = (GAP == 0) ? S_IDLE : S_GAP;
            default: if (r_gcnt == GLAST) w_next = S_IDLE;
        endcase
    end

    // r_key keeps the selected word intact while r_shreg is consumed by shifting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg   <= '0;
            r_key     <= '0;
            r_cnt     <= '0;
            r_gcnt    <= '0;
            r_key_bus <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_shreg <= w_sel;
                r_key   <= w_sel;
                r_cnt   <= 5'd18;
            end else if (w_xfer) begin
                r_shreg <= {r_shreg[17:0], 1'b0};
                r_cnt   <= r_cnt - 5'd1;
            end
            r_gcnt <= (r_state == S_GAP) ? r_gcnt + GW'(1) : '0;
            if (w_last) r_key_bus <= r_key;
        end
    end

`ifdef MUNDO4_TX_CHK_EN
    logic r_match;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_match <= 1'b0;
        else if (w_last) r_match <= (r_key == KEY0) || (r_key == KEY1);
    end
    assign o_match = r_match;
`else
    assign o_match = 1'b0;
`endif

    assign o_ser_valid = (r_state == S_SHIFT);
    assign o_ser_data  = (r_state == S_SHIFT) && r_shreg[18];
    assign o_ser_sof   = (r_state == S_SHIFT) && (r_cnt == 5'd18);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_FIN);
    assign o_key_bus   = r_key_bus;
endmodule

// File: tb/tb_mundo4_key_tx.sv
// tb_mundo4_key_tx: table-driven and randomized frame checks for mundo4_key_tx against a word-level model.
module tb_mundo4_key_tx;
    localparam int GAP = 2;
    localparam logic [18:0] KEY0 = 19'h29810;
    localparam logic [18:0] KEY1 = 19'h3FFFF;
`ifdef MUNDO4_TX_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, key_sel = 1'b0, ser_ready = 1'b0;
    logic        ser_data, ser_valid, ser_sof, busy, done, match;
    logic [18:0] key_bus;
    logic [18:0] prev_key = '0;
    int          n_chk = 0, n_pass = 0;

    typedef struct {
        logic        ksel;
        int          mode;
        logic [18:0] exp_key;
        int          exp_done;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    mundo4_key_tx #(.GAP(GAP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_key_sel(key_sel),
        .i_ser_ready(ser_ready), .o_ser_data(ser_data), .o_ser_valid(ser_valid),
        .o_ser_sof(ser_sof), .o_busy(busy), .o_done(done), .o_key_bus(key_bus),
        .o_match(match)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, ser_data, 0);
        chk({tag, "_valid"}, ser_valid, 0);
        chk({tag, "_sof"}, ser_sof, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_key_bus"}, key_bus, 0);
        chk({tag, "_match"}, match, 0);
    endtask

    // mode: 0 ready always high, 1 ready toggles 1,0,1,..., 2 random ready; exp_done 0 means 20 + stalls
    task automatic run_frame(input logic ksel, input int mode, input logic [18:0] exp_key, input int exp_done);
        int idx = 0, stalls = 0, cyc = 1;
        bit tog = 1'b1, seen = 1'b0;
        @(negedge clk);
        chk("idle_before_start", busy, 0);
        start = 1'b1;
        key_sel = ksel;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 200) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (idx > 18) begin
                chk("bit_overrun", idx, 18);
                break;
            end
            chk("ser_valid", ser_valid, 1);
            chk("ser_sof", ser_sof, idx == 0);
            chk("ser_data", ser_data, exp_key[18-idx]);
            chk("key_bus_hold", key_bus, prev_key);
            chk("busy_shift", busy, 1);
            ser_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            start = 1'($urandom_range(0, 1));
            key_sel = 1'($urandom_range(0, 1));
            if (ser_ready) idx++;
            else stalls++;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", seen, 1);
        chk("done_cycle", cyc, (exp_done != 0) ? exp_done : 20 + stalls);
        chk("bits_sent", idx, 19);
        chk("key_bus_fin", key_bus, exp_key);
        chk("match_fin", match, CHK);
        chk("fin_valid", ser_valid, 0);
        prev_key = exp_key;
        start = 1'b1;
        ser_ready = 1'b0;
        for (int g = 0; g < GAP; g++) begin
            @(negedge clk);
            chk("gap_busy", busy, 1);
            chk("gap_done", done, 0);
            chk("gap_key_bus", key_bus, exp_key);
        end
        start = 1'b0;
        @(negedge clk);
        chk("busy_fall", busy, 0);
        chk("start_not_queued", ser_valid, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 0, KEY0, 20};
        vecs[1] = '{1'b1, 0, KEY1, 20};
        vecs[2] = '{1'b0, 1, KEY0, 38};
        vecs[3] = '{1'b1, 1, KEY1, 38};
        vecs[4] = '{1'b0, 2, KEY0, 0};
        vecs[5] = '{1'b1, 2, KEY1, 0};

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].ksel, vecs[i].mode, vecs[i].exp_key, vecs[i].exp_done);

        for (int i = 0; i < 8; i++) begin
            logic ks;
            ks = 1'($urandom_range(0, 1));
            run_frame(ks, 2, ks ? KEY1 : KEY0, 0);
        end

        // abort a KEY1 frame after 7 bits with an asynchronous reset
        @(negedge clk);
        start = 1'b1;
        key_sel = 1'b1;
        ser_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_mid_valid", ser_valid, 1);
        chk("abort_mid_data", ser_data, KEY1[11]);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        prev_key = '0;
        run_frame(1'b0, 0, KEY0, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
